// File: rtl/ifetch_unit.sv
// Instruction fetch: samples curPC, fetches over a req/ack memory port and hands the word
// to decode over valid/ready, advancing the PC register only once decode has taken it.
module ifetch_unit #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] curPC,
  output logic              PCWre,
  input  logic              flush,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_out,
  output logic [DATA_W-1:0] inst_pc,
  output logic              fetch_fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN,
    S_HOLD,
    S_FAULT
  } state_t;

  // Fault fires on the edge where the wait counter would reach TIMEOUT.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic                fault_q, fault_d;
  logic [7:0]          cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      pc_q    <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    out_d   = out_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    PCWre   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (curPC[1:0] != 2'b00) begin
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          addr_d  = curPC;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem_ack) begin
          req_d = 1'b0;
          if (!flush) begin
            out_d   = imem_rdata;
            pc_d    = addr_q;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end else begin
            state_d = S_IDLE;
          end
        end else if (cnt_q == TMO_LAST) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (flush) state_d = S_DRAIN;
        end
      end

      // A flushed request must still be retired by its ack before a new one goes out.
      S_DRAIN: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_HOLD: begin
        PCWre = valid_q & inst_ready & ~flush;
        if (flush || inst_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_FAULT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign inst_valid  = valid_q;
  assign inst_out    = out_q;
  assign inst_pc     = pc_q;
  assign fetch_fault = fault_q;

endmodule
